// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of a 32x32 register file port.
// After reset it sweeps r0..r31 with data = index before accepting requests.
module regfile_wb_arbiter #(
    parameter int NREQ    = 3,
    parameter bit INIT_EN = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*5-1:0]  req_reg_num,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               reg_write,
    output logic [4:0]         wr_reg_num,
    output logic [31:0]        wr_data,
    output logic               init_done
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [4:0]  reg_num;
        logic [31:0] data;
    } wb_req_t;

    state_t              state, state_next;
    logic [4:0]          cnt;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       grant_idx;
    logic                grant_any;
    logic                fire;
    wb_req_t [NREQ-1:0]  req;

    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign req[k] = {req_reg_num[5*k +: 5], req_data[32*k +: 32]};
    end

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return GW'(s);
    endfunction

    // Search starts one past the last winner so every requester waits at most NREQ-1 grants.
    always_comb begin
        grant_idx = last_grant;
        grant_any = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            if (!grant_any && req_valid[rr_idx(last_grant, off)]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx(last_grant, off);
            end
        end
    end

    // init_done (not state) gates acceptance, and reset masks ready so nothing is handshaken during it.
    assign fire      = grant_any && init_done && !reset;
    assign req_ready = fire ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (cnt == 5'd31) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT_EN ? INIT : RUN;
            cnt        <= 5'd0;
            last_grant <= GW'(NREQ - 1);
            reg_write  <= 1'b0;
            wr_reg_num <= 5'd0;
            wr_data    <= 32'd0;
            init_done  <= 1'b0;
        end else begin
            state     <= state_next;
            init_done <= (state_next == RUN);
            if (state == INIT) begin
                reg_write  <= 1'b1;
                wr_reg_num <= cnt;
                wr_data    <= {27'b0, cnt};
                if (cnt != 5'd31) cnt <= cnt + 5'd1;
            end else if (fire) begin
                // r0 requests are consumed but never written so r0 stays zero.
                reg_write  <= (req[grant_idx].reg_num != 5'd0);
                wr_reg_num <= req[grant_idx].reg_num;
                wr_data    <= req[grant_idx].data;
                last_grant <= grant_idx;
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: init sweep, grants, r0 drop, resets.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_reg_num;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        reg_write;
    logic [4:0]  wr_reg_num;
    logic [31:0] wr_data;
    logic        init_done;

    int nvec = 0;
    int nerr = 0;

    regfile_wb_arbiter #(.NREQ(3), .INIT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_reg_num(req_reg_num),
        .req_data(req_data), .req_ready(req_ready), .reg_write(reg_write),
        .wr_reg_num(wr_reg_num), .wr_data(wr_data), .init_done(init_done)
    );

    always #5 clock = ~clock;

    task automatic set_req(input int k, input logic [4:0] r, input logic [31:0] d);
        req_reg_num[5*k +: 5]  = r;
        req_data[32*k +: 32]   = d;
    endtask

    task automatic test_reset;
        req_valid = 3'b111;
        repeat (2) @(posedge clock);
        #1;
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL rst_reg_write got %b want 0", reg_write); end
        nvec++; if (wr_reg_num !== 5'd0) begin nerr++; $display("FAIL rst_wr_reg_num got %0d want 0", wr_reg_num); end
        nvec++; if (wr_data !== 32'd0) begin nerr++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
        nvec++; if (init_done !== 1'b0) begin nerr++; $display("FAIL rst_init_done got %b want 0", init_done); end
        nvec++; if (req_ready !== 3'b000) begin nerr++; $display("FAIL rst_req_ready got %b want 000", req_ready); end
        req_valid = 3'b000;
        reset = 1'b0;
        @(negedge clock);
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL post_rst_idle got %b want 0", reg_write); end
    endtask

    task automatic test_init_sweep;
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); @(negedge clock);
            nvec++;
            if (reg_write !== 1'b1 || wr_reg_num !== 5'(i) || wr_data !== 32'(i) || init_done !== (i == 31)) begin
                nerr++;
                $display("FAIL sweep[%0d] got we=%b r=%0d d=%h done=%b want we=1 r=%0d d=%h done=%b",
                         i, reg_write, wr_reg_num, wr_data, init_done, i, i, (i == 31));
            end
        end
        @(posedge clock); @(negedge clock);
        nvec++;
        if (reg_write !== 1'b0 || wr_reg_num !== 5'd31 || init_done !== 1'b1) begin
            nerr++;
            $display("FAIL sweep_end got we=%b r=%0d done=%b want we=0 r=31 done=1", reg_write, wr_reg_num, init_done);
        end
    endtask

    // Reset from RUN with requests pending, then hold requests through the sweep.
    task automatic test_init_requests;
        for (int k = 0; k < 3; k++) set_req(k, 5'(20 + k), 32'h5000 + k);
        req_valid = 3'b111;
        reset = 1'b1;
        #1;
        nvec++; if (req_ready !== 3'b000) begin nerr++; $display("FAIL ready_in_reset got %b want 000", req_ready); end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); @(negedge clock);
            nvec++;
            if (req_ready !== ((i == 31) ? 3'b001 : 3'b000) || wr_reg_num !== 5'(i)) begin
                nerr++;
                $display("FAIL init_ready[%0d] got rdy=%b r=%0d want rdy=%b r=%0d",
                         i, req_ready, wr_reg_num, ((i == 31) ? 3'b001 : 3'b000), i);
            end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_round_robin;
        for (int k = 0; k < 3; k++) set_req(k, 5'(10 + k), 32'hA000 + k);
        req_valid = 3'b111;
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) req_valid = 3'b000;
            #1;
            nvec++;
            if (req_ready !== ((c < 6) ? (3'b001 << (c % 3)) : 3'b000)) begin
                nerr++;
                $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, ((c < 6) ? (3'b001 << (c % 3)) : 3'b000));
            end
            if (c > 0) begin
                nvec++;
                if (reg_write !== 1'b1 || wr_reg_num !== 5'(10 + (c - 1) % 3) || wr_data !== 32'hA000 + (c - 1) % 3) begin
                    nerr++;
                    $display("FAIL rr_write[%0d] got we=%b r=%0d d=%h want we=1 r=%0d d=%h",
                             c, reg_write, wr_reg_num, wr_data, 10 + (c - 1) % 3, 32'hA000 + (c - 1) % 3);
                end
            end
            @(negedge clock);
        end
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL rr_idle got %b want 0", reg_write); end
    endtask

    task automatic test_single_alu;
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL alu_ready got %b want 001", req_ready); end
        @(posedge clock); #1;
        req_valid = 3'b000;
        @(negedge clock);
        nvec++;
        if (reg_write !== 1'b1 || wr_reg_num !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL alu_write got we=%b r=%0d d=%h want we=1 r=5 d=deadbeef", reg_write, wr_reg_num, wr_data);
        end
        @(negedge clock);
        nvec++;
        if (reg_write !== 1'b0 || wr_reg_num !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL alu_hold got we=%b r=%0d d=%h want we=0 r=5 d=deadbeef", reg_write, wr_reg_num, wr_data);
        end
    endtask

    task automatic test_r0_write;
        set_req(1, 5'd0, 32'h1234);
        req_valid = 3'b010;
        #1;
        nvec++; if (req_ready !== 3'b010) begin nerr++; $display("FAIL r0_ready got %b want 010", req_ready); end
        @(posedge clock); #1;
        req_valid = 3'b000;
        @(negedge clock);
        nvec++; if (reg_write !== 1'b0) begin nerr++; $display("FAIL r0_reg_write got %b want 0", reg_write); end
    endtask

    // last_grant is 1 here, so requester 2 wins before requester 0.
    task automatic test_same_reg_order;
        set_req(0, 5'd9, 32'h111);
        set_req(2, 5'd9, 32'h222);
        req_valid = 3'b101;
        #1;
        nvec++; if (req_ready !== 3'b100) begin nerr++; $display("FAIL order_ready0 got %b want 100", req_ready); end
        @(negedge clock);
        req_valid = 3'b001;
        #1;
        nvec++; if (req_ready !== 3'b001) begin nerr++; $display("FAIL order_ready1 got %b want 001", req_ready); end
        nvec++;
        if (reg_write !== 1'b1 || wr_reg_num !== 5'd9 || wr_data !== 32'h222) begin
            nerr++;
            $display("FAIL order_write0 got we=%b r=%0d d=%h want we=1 r=9 d=222", reg_write, wr_reg_num, wr_data);
        end
        @(posedge clock); #1;
        req_valid = 3'b000;
        @(negedge clock);
        nvec++;
        if (reg_write !== 1'b1 || wr_reg_num !== 5'd9 || wr_data !== 32'h111) begin
            nerr++;
            $display("FAIL order_write1 got we=%b r=%0d d=%h want we=1 r=9 d=111", reg_write, wr_reg_num, wr_data);
        end
    endtask

    task automatic test_reset_mid_init;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); @(negedge clock);
            nvec++;
            if (wr_reg_num !== 5'(i)) begin nerr++; $display("FAIL pre_abort[%0d] got r=%0d want %0d", i, wr_reg_num, i); end
        end
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        nvec++;
        if (reg_write !== 1'b0 || init_done !== 1'b0) begin
            nerr++;
            $display("FAIL abort_rst got we=%b done=%b want we=0 done=0", reg_write, init_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); @(negedge clock);
            nvec++;
            if (reg_write !== 1'b1 || wr_reg_num !== 5'(i) || wr_data !== 32'(i) || init_done !== (i == 31)) begin
                nerr++;
                $display("FAIL resweep[%0d] got we=%b r=%0d d=%h done=%b want we=1 r=%0d d=%h done=%b",
                         i, reg_write, wr_reg_num, wr_data, init_done, i, i, (i == 31));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 3'b000;
        req_reg_num = '0;
        req_data    = '0;
        test_reset();
        test_init_sweep();
        test_init_requests();
        test_round_robin();
        test_single_alu();
        test_r0_write();
        test_same_reg_order();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
